// File: rtl/elev_pkg.sv
// Shared elevator definitions: travel-direction encoding and the hall-call record.
package elev_pkg;

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam int   FLOOR_W_MAX = 8;

  typedef struct packed {
    logic [FLOOR_W_MAX-1:0] floor;
    logic                   dir;
  } hall_call_t;

endpackage

// File: rtl/call_scan_sel.sv
// Combinational collective-control picker: chooses the next hall call to serve
// from the latch vector, the car position and its travel direction.
module call_scan_sel
  import elev_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FW       = $clog2(N_FLOORS)
) (
  input  logic [2*N_FLOORS-1:0] latches,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  cur_dir,
  output logic                  hit,
  output logic [FW-1:0]         floor,
  output logic                  dir
);

  logic [N_FLOORS-1:0] up_lat;
  logic [N_FLOORS-1:0] dn_lat;

  assign up_lat = latches[N_FLOORS-1:0];
  assign dn_lat = latches[2*N_FLOORS-1:N_FLOORS];

  function automatic logic bit_at(logic [N_FLOORS-1:0] v, int i);
    logic [N_FLOORS-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Three passes per direction; the first pass that finds a call wins.
  always_comb begin
    int cur;
    cur   = (int'(cur_floor) >= N_FLOORS) ? N_FLOORS - 1 : int'(cur_floor);
    hit   = 1'b0;
    floor = '0;
    dir   = DIR_UP;
    if (cur_dir == DIR_UP) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (!hit && f >= cur && bit_at(up_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_UP;
        end
      end
      for (int f = N_FLOORS - 1; f >= 0; f--) begin
        if (!hit && bit_at(dn_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_DOWN;
        end
      end
      for (int f = 0; f < N_FLOORS; f++) begin
        if (!hit && bit_at(up_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_UP;
        end
      end
    end else begin
      for (int f = N_FLOORS - 1; f >= 0; f--) begin
        if (!hit && f <= cur && bit_at(dn_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_DOWN;
        end
      end
      for (int f = 0; f < N_FLOORS; f++) begin
        if (!hit && bit_at(up_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_UP;
        end
      end
      for (int f = N_FLOORS - 1; f >= 0; f--) begin
        if (!hit && bit_at(dn_lat, f)) begin
          hit = 1'b1; floor = FW'(f); dir = DIR_DOWN;
        end
      end
    end
  end

endmodule

// File: rtl/hall_call_sched.sv
// Hall-call scheduler: latches up/down presses per floor and hands the car
// one call per done request, clearing the granted latch as it is issued.
module hall_call_sched
  import elev_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FW       = $clog2(N_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FW-1:0]         req_floor,
  input  logic                  req_dir,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  cur_dir,
  input  logic                  done,
  output logic                  grant_valid,
  output logic [FW-1:0]         grant_floor,
  output logic                  grant_dir,
  output logic [2*N_FLOORS-1:0] pending,
  output logic                  empty,
  output logic                  req_err
);

  localparam int             NL  = 2 * N_FLOORS;
  localparam logic [NL-1:0]  ONE = {{(NL-1){1'b0}}, 1'b1};

  logic [NL-1:0] pending_q, pending_d;
  logic          grant_valid_q, grant_valid_d;
  logic [FW-1:0] grant_floor_q, grant_floor_d;
  logic          grant_dir_q, grant_dir_d;
  logic          req_err_q, req_err_d;

  logic          sel_hit;
  logic [FW-1:0] sel_floor;
  logic          sel_dir;
  logic          req_bad;
  logic          grant_now;
  logic [NL-1:0] set_mask;
  logic [NL-1:0] clr_mask;

  call_scan_sel #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_sel (
    .latches   (pending_q),
    .cur_floor (cur_floor),
    .cur_dir   (cur_dir),
    .hit       (sel_hit),
    .floor     (sel_floor),
    .dir       (sel_dir)
  );

  // Clear is applied after set so a press on the latch being granted is absorbed.
  always_comb begin
    int req_idx;
    int clr_idx;
    req_bad = (int'(req_floor) >= N_FLOORS)
           || (req_dir == DIR_UP   && int'(req_floor) == N_FLOORS - 1)
           || (req_dir == DIR_DOWN && req_floor == '0);
    req_idx = (req_dir == DIR_DOWN) ? N_FLOORS + int'(req_floor) : int'(req_floor);
    set_mask = '0;
    if (req_valid && !req_bad) set_mask = ONE << req_idx;

    grant_now = done && sel_hit;
    clr_idx   = (sel_dir == DIR_DOWN) ? N_FLOORS + int'(sel_floor) : int'(sel_floor);
    clr_mask  = '0;
    if (grant_now) clr_mask = ONE << clr_idx;

    pending_d     = (pending_q | set_mask) & ~clr_mask;
    grant_valid_d = grant_now;
    grant_floor_d = grant_now ? sel_floor : grant_floor_q;
    grant_dir_d   = grant_now ? sel_dir : grant_dir_q;
    req_err_d     = req_valid && req_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_floor_q <= '0;
      grant_dir_q   <= DIR_UP;
      req_err_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      grant_valid_q <= grant_valid_d;
      grant_floor_q <= grant_floor_d;
      grant_dir_q   <= grant_dir_d;
      req_err_q     <= req_err_d;
    end
  end

  assign pending     = pending_q;
  assign empty       = (pending_q == '0);
  assign grant_valid = grant_valid_q;
  assign grant_floor = grant_floor_q;
  assign grant_dir   = grant_dir_q;
  assign req_err     = req_err_q;

endmodule
